// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP fixed-point datapath (Q3.16 activations).
package mlp_pkg;

  localparam int DW   = 20;
  localparam int FRAC = 16;

  typedef logic signed [DW-1:0]     fx_t;
  typedef logic signed [2*DW-1:0]   prod_t;
  typedef logic signed [2*DW+1:0]   acc_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    FIN,
    HOLD
  } cls_state_t;

  localparam fx_t FX_MAX = 20'h7FFFF;
  localparam fx_t FX_MIN = 20'h80000;

endpackage

// File: rtl/mlp_output_classifier_fx_sat.sv
// fx_sat: converts a Q6.32 accumulator to Q3.16 with floor shift and saturation.
// The clip flag output exists only when MLP_CLS_OVF_FLAG_EN is defined.
module fx_sat
  import mlp_pkg::*;
(
  input  logic signed [2*DW+1:0] acc_i,
  output logic signed [DW-1:0]   sat_o
`ifdef MLP_CLS_OVF_FLAG_EN
  ,
  output logic                   ovf_o
`endif
);

  acc_t shifted;
  logic too_big;
  logic too_small;

  assign shifted   = acc_i >>> FRAC;
  assign too_big   = shifted > acc_t'(FX_MAX);
  assign too_small = shifted < acc_t'(FX_MIN);

  always_comb begin
    sat_o = shifted[DW-1:0];
    if (too_big) begin
      sat_o = FX_MAX;
    end else if (too_small) begin
      sat_o = FX_MIN;
    end
  end

`ifdef MLP_CLS_OVF_FLAG_EN
  assign ovf_o = too_big | too_small;
`endif

endmodule

// File: rtl/mlp_output_classifier.sv
// Output neuron: score = W0*x + W1*y + W2*z + BIAS on one shared multiplier, then sign threshold.
// Define MLP_CLS_OVF_FLAG_EN to add the registered saturation flag output ovf.
module mlp_output_classifier
  import mlp_pkg::*;
#(
  parameter logic [DW-1:0] W0   = 20'h10000,
  parameter logic [DW-1:0] W1   = 20'hE0000,
  parameter logic [DW-1:0] W2   = 20'h08000,
  parameter logic [DW-1:0] BIAS = 20'hFC000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  input  logic [DW-1:0] z_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] score,
  output logic          class_out
`ifdef MLP_CLS_OVF_FLAG_EN
  ,
  output logic          ovf
`endif
);

  cls_state_t state_q, state_d;
  fx_t        x_q, x_d;
  fx_t        y_q, y_d;
  fx_t        z_q, z_d;
  acc_t       acc_q, acc_d;
  fx_t        score_q, score_d;
  logic       class_q, class_d;
  fx_t        op_a;
  fx_t        op_b;
  prod_t      prod;
  fx_t        sat_score;

  assign prod = prod_t'(op_a) * prod_t'(op_b);

`ifdef MLP_CLS_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic sat_ovf;

  fx_sat u_fx_sat (
    .acc_i (acc_q),
    .sat_o (sat_score),
    .ovf_o (sat_ovf)
  );

  assign ovf = ovf_q;
`else
  fx_sat u_fx_sat (
    .acc_i (acc_q),
    .sat_o (sat_score)
  );
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    acc_d   = acc_q;
    score_d = score_q;
    class_d = class_q;
    op_a    = '0;
    op_b    = '0;
`ifdef MLP_CLS_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          // Bias pre-scaled to Q6.32 so the products add in directly.
          acc_d   = acc_t'($signed(BIAS)) <<< FRAC;
          state_d = MAC0;
        end
      end
      MAC0: begin
        op_a    = x_q;
        op_b    = $signed(W0);
        acc_d   = acc_q + acc_t'(prod);
        state_d = MAC1;
      end
      MAC1: begin
        op_a    = y_q;
        op_b    = $signed(W1);
        acc_d   = acc_q + acc_t'(prod);
        state_d = MAC2;
      end
      MAC2: begin
        op_a    = z_q;
        op_b    = $signed(W2);
        acc_d   = acc_q + acc_t'(prod);
        state_d = FIN;
      end
      FIN: begin
        score_d = sat_score;
        class_d = ~sat_score[DW-1];
`ifdef MLP_CLS_OVF_FLAG_EN
        ovf_d   = sat_ovf;
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      score_q <= '0;
      class_q <= 1'b0;
`ifdef MLP_CLS_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      class_q <= class_d;
`ifdef MLP_CLS_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign score     = score_q;
  assign class_out = class_q;

endmodule

// File: tb/tb_mlp_output_classifier.sv
// Directed self-checking bench for mlp_output_classifier; also checks ovf when MLP_CLS_OVF_FLAG_EN is defined.
module tb_mlp_output_classifier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] x_in;
  logic [19:0] y_in;
  logic [19:0] z_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] score;
  logic        class_out;
`ifdef MLP_CLS_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks;
  int errors;

  mlp_output_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .score     (score),
    .class_out (class_out)
`ifdef MLP_CLS_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One transaction: offer the input, time the result, then optionally stall the output.
  task automatic applyStimulus(input string tag, input logic [19:0] xv, input logic [19:0] yv,
                               input logic [19:0] zv, input logic [19:0] exp_score,
                               input logic exp_class, input logic exp_ovf, input int stall);
    int lat;
    @(negedge clk);
    x_in      = xv;
    y_in      = yv;
    z_in      = zv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = 20'h55555;
    y_in     = 20'h55555;
    z_in     = 20'h55555;
    lat      = 0;
    checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_score"}, 32'(score), 32'(exp_score));
    checkOutput({tag, "_class"}, 32'(class_out), 32'(exp_class));
`ifdef MLP_CLS_OVF_FLAG_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf && !out_valid) $display("[TB] note %s: no valid output", tag);
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_score"}, 32'(score), 32'(exp_score));
      checkOutput({tag, "_hold_class"}, 32'(class_out), 32'(exp_class));
      checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_score", 32'(score), 32'd0);
    checkOutput("reset_class", 32'(class_out), 32'd0);
    rst = 1'b1;

    applyStimulus("nominal",  20'h10000, 20'h00000, 20'h08000, 20'h10000, 1'b1, 1'b0, 0);
    applyStimulus("negative", 20'h00000, 20'h10000, 20'h00000, 20'hDC000, 1'b0, 1'b0, 3);
    applyStimulus("zero",     20'h00000, 20'h00000, 20'h08000, 20'h00000, 1'b1, 1'b0, 0);
    applyStimulus("sat_pos",  20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h7FFFF, 1'b1, 1'b1, 0);
    applyStimulus("sat_neg",  20'h80000, 20'h7FFFF, 20'h80000, 20'h80000, 1'b0, 1'b1, 0);
    applyStimulus("neg_y",    20'h00000, 20'hF0000, 20'h00000, 20'h1C000, 1'b1, 1'b0, 0);
    applyStimulus("floor",    20'h00000, 20'h00000, 20'h00001, 20'hFC000, 1'b0, 1'b0, 0);
    applyStimulus("lsb",      20'h00001, 20'h00000, 20'h00000, 20'hFC001, 1'b0, 1'b0, 1);

    // Reset lands while the block is in MAC1; the partial result must vanish.
    @(negedge clk);
    x_in     = 20'h7FFFF;
    y_in     = 20'h80000;
    z_in     = 20'h7FFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_score", 32'(score), 32'd0);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_no_output", 32'(out_valid), 32'd0);
    end
    applyStimulus("after_rst", 20'h10000, 20'h00000, 20'h08000, 20'h10000, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
